// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO, L words of DATA_W bits, registered read data.
//            Define SYNC_FIFO_LEVEL_EN to add level/overflow/underflow outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int L      = 10,
  localparam int ADD_W  = $clog2(L)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
`ifdef SYNC_FIFO_LEVEL_EN
  output logic [ADD_W:0]    level,
  output logic              overflow,
  output logic              underflow,
`endif
  output logic              full,
  output logic              empty
);

  localparam logic [ADD_W:0]   c_DEPTH = (ADD_W+1)'(L);
  localparam logic [ADD_W-1:0] c_LAST  = ADD_W'(L - 1);

  logic [DATA_W-1:0] r_mem [L];
  logic [ADD_W-1:0]  r_wr_ptr;
  logic [ADD_W-1:0]  r_rd_ptr;
  logic [ADD_W:0]    r_count;
  logic [DATA_W-1:0] r_dout;

  logic w_wr_ok;
  logic w_rd_ok;

  // Flags come only from the registered count, never from the enables.
  assign full    = (r_count == c_DEPTH);
  assign empty   = (r_count == '0);
  assign w_wr_ok = wr_en & ~full;
  assign w_rd_ok = rd_en & ~empty;
  assign dout    = r_dout;

  // Storage is deliberately not reset; rst only blocks writes in its cycle.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd_ok && !w_wr_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_LEVEL_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en & full;
      r_underflow <= rd_en & empty;
    end
  end

  assign level     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Directed scoreboard bench for sync_fifo (DATA_W=8, L=10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo;

  localparam int DATA_W = 8;
  localparam int L      = 10;
  localparam int ADD_W  = $clog2(L);

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [ADD_W:0]    level;
  logic              overflow;
  logic              underflow;
`endif

  sync_fifo #(.DATA_W(DATA_W), .L(L)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
`ifdef SYNC_FIFO_LEVEL_EN
    .level     (level),
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_dout = '0;
  logic              exp_ovf  = 1'b0;
  logic              exp_udf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"},  32'(dout),  32'(exp_dout));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(q.size() == L));
`ifdef SYNC_FIFO_LEVEL_EN
    chk({tag, ".level"}, 32'(level),     32'(q.size()));
    chk({tag, ".ovf"},   32'(overflow),  32'(exp_ovf));
    chk({tag, ".udf"},   32'(underflow), 32'(exp_udf));
`endif
  endtask

  // One clock with the given enables; the model decides acceptance on pre-edge occupancy.
  task automatic cycle(input string tag, input logic w, input logic r, input logic [DATA_W-1:0] d);
    bit wok, rok;
    wok = w && (q.size() < L);
    rok = r && (q.size() > 0);
    exp_ovf = w && (q.size() == L);
    exp_udf = r && (q.size() == 0);
    rst = 1'b0; wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    #1;
    if (rok) exp_dout = q.pop_front();
    if (wok) q.push_back(d);
    wr_en = 1'b0; rd_en = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 8'hEE;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    q.delete();
    exp_dout = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    check_all("reset");
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    @(negedge clk);

    // Reset with enables active
    do_reset(3);

    // Basic ordering
    for (int i = 1; i <= 3; i++) cycle("basic_wr", 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 3; i++) cycle("basic_rd", 1'b0, 1'b1, 8'h00);
    cycle("basic_hold", 1'b0, 1'b0, 8'h00);

    // Fill, overflow, drain
    for (int i = 0; i < L; i++) cycle("fill", 1'b1, 1'b0, 8'h10 + 8'(i));
    cycle("overflow", 1'b1, 1'b0, 8'hAA);
    cycle("ovf_clear", 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < L; i++) cycle("drain", 1'b0, 1'b1, 8'h00);

    // Underflow
    cycle("underflow0", 1'b0, 1'b1, 8'h00);
    cycle("underflow1", 1'b0, 1'b1, 8'h00);

    // Simultaneous access while empty: write wins, read ignored
    cycle("rw_empty", 1'b1, 1'b1, 8'h77);
    cycle("rw_empty_rd", 1'b0, 1'b1, 8'h00);

    // Preload then simultaneous read/write across pointer wraps
    d = 8'h40;
    for (int i = 0; i < 5; i++) begin cycle("preload", 1'b1, 1'b0, d); d++; end
    for (int i = 0; i < 20; i++) begin cycle("rw_wrap", 1'b1, 1'b1, d); d++; end

    // Fill to full, then simultaneous read/write: write rejected, read accepted
    while (q.size() < L) begin cycle("refill", 1'b1, 1'b0, d); d++; end
    cycle("rw_full", 1'b1, 1'b1, 8'hBB);
    cycle("rw_full_wr", 1'b1, 1'b0, 8'hCC);

    // Reset mid-operation with 4 words stored
    while (q.size() > 4) cycle("trim", 1'b0, 1'b1, 8'h00);
    do_reset(1);
    cycle("post_rst_wr", 1'b1, 1'b0, 8'h55);
    cycle("post_rst_rd", 1'b0, 1'b1, 8'h00);
    cycle("post_rst_hold", 1'b0, 1'b1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, synchronous first-in first-out buffer of L words, each DATA_W bits wide.
- Decouples a producer and a consumer in the same clock domain with write/read enables and full/empty status.
- Storage is a register array. Pointers wrap at L, and L need not be a power of two.
- Read data is registered, with one-cycle latency.

Parameters:
- DATA_W, default 8: data word width in bits.
- L, default 10: depth in words, L >= 2.
- ADD_W, default $clog2(L): pointer width. It is derived and must not be overridden.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request; din is captured on the clk edge when accepted.
- rd_en  input  1  read request; the head word appears on dout after the clk edge when accepted.
- din  input  DATA_W  write data.
- dout  output  DATA_W  registered read data.
- full  output  1  high when the FIFO holds L words.
- empty  output  1  high when the FIFO holds 0 words.

Interface note: one clock; reset is synchronous and active-high (ports clk and rst).

Behaviour:
- State: memory array mem[0..L-1], wr_ptr and rd_ptr (ADD_W bits), count (ADD_W+1 bits, range 0..L), dout register.
- Reset (rst=1 at a clk edge):
  - wr_ptr=0, rd_ptr=0, count=0, dout=0, so empty=1 and full=0.
  - Memory contents are not cleared.
  - rst has priority over wr_en and rd_en.
  - A reset mid-operation discards all stored data in that same cycle.
- Accept conditions:
  - wr_ok = wr_en & !full.
  - rd_ok = rd_en & !empty.
  - Both are evaluated on the pre-edge flags.
- Write (wr_ok): mem[wr_ptr] <= din; wr_ptr advances by 1, wrapping L-1 -> 0.
- Read (rd_ok): dout <= mem[rd_ptr]; rd_ptr advances by 1, wrapping L-1 -> 0.
  - Latency: the data is valid on dout after the same edge that accepts the read.
- dout holds its last value when no read is accepted, including rd_en while empty.
- count update per edge:
  - wr_ok only: +1.
  - rd_ok only: -1.
  - Both, or neither: unchanged.
- Simultaneous read and write:
  - While not full and not empty: both proceed, and the read returns the old head word, never the word being written.
  - When empty: the read is ignored and the write is accepted; the written word becomes readable from the next cycle.
  - When full: the write is rejected even if a read occurs in the same cycle; the read is accepted.
- Overflow (write while full): dropped silently. No pointer, count or memory change.
- Underflow (read while empty): ignored silently. dout is unchanged.
- Flags are decoded combinationally from registered count: full = (count==L), empty = (count==0). There is no combinational path from inputs to flags.
- Ordering: words are read in exactly the order written, across any number of pointer wraps.
- X on wr_en or rd_en during reset must not corrupt the post-reset state.

Optional Feature:
- Macro: SYNC_FIFO_LEVEL_EN.
- Defined:
  - Adds output port level [ADD_W:0], equal to the registered count (0..L), reset 0.
  - Adds output ports overflow and underflow, 1 bit each, registered.
  - overflow pulses high for one cycle after an edge where wr_en=1 and full=1.
  - underflow pulses high for one cycle after an edge where rd_en=1 and empty=1.
  - Both pulses reset to 0.
- Not defined: these ports and their logic do not exist. The core FIFO behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=1 for 3 edges with wr_en and rd_en driven to X/1 -> empty=1, full=0, dout=0.
- Basic order: write 1, 2, 3 on consecutive edges, then rd_en=1 for 3 edges.
  - dout = 1, 2, 3 after the successive read edges.
  - empty=1 after the third read; dout then holds 3.
- Fill and overflow:
  - Write 10 words (0x10..0x19) -> full=1 after the 10th edge.
  - An 11th write of 0xAA is dropped; reading 10 words returns 0x10..0x19, then empty=1.
- Underflow: rd_en=1 while empty for 2 edges -> dout unchanged, count stays 0, empty stays 1.
- Wrap-around and simultaneous access:
  - Preload 5 words, then drive wr_en=rd_en=1 for 20 edges with incrementing data.
  - Count stays 5 throughout; the read sequence is continuous with no loss or duplication across pointer wraps at 9 -> 0.
- Reset mid-operation: with 4 words stored, assert rst for 1 edge -> empty=1, dout=0. A subsequent write of 0x55 then a read returns 0x55.
